mp_addsub_serial: RTL

- Multi-cycle, limb-serial 514-bit adder/subtractor.
- Acts as the responder side of the start/done handshake used by the modular-reduction and exponentiation controllers.
- The controller pulses start with operands; this block computes a+b or a−b one LIMB-wide slice per cycle, then pulses done with a WIDTH+1-bit result.
- Bit WIDTH of the result is the carry on add and the sign (borrow) on subtract, so the controller can branch on it directly.

---
 rtl/mp_addsub_serial.sv | 119 +++++++++++
 1 files changed

// File: rtl/mp_addsub_serial.sv
// Limb-serial multi-precision adder/subtractor.
// Processes one LIMB-wide slice per cycle and returns a WIDTH+1-bit result whose
// top bit is the carry (add) or the borrow/sign (subtract).
module mp_addsub_serial #(
    parameter int unsigned WIDTH = 514,
    parameter int unsigned LIMB  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH:0]   result,
    output logic             done
);

    // ceil((WIDTH+1)/LIMB): one extra bit so the carry/sign lands inside the datapath
    localparam int unsigned NLIMB = (WIDTH + LIMB) / LIMB;
    localparam int unsigned P     = NLIMB * LIMB;
    localparam int unsigned CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [CW-1:0] LAST_LIMB = CW'(NLIMB - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [P-1:0]  a_q, b_q, sum_q;
    logic          carry_q;
    logic [CW-1:0] cnt_q;
    logic [WIDTH:0] result_q;
    logic          done_q;

    logic          load, step, finish;
    logic [P-1:0]  a_ext, b_ext;
    logic [LIMB:0] limb_sum;

    assign a_ext = {{(P - WIDTH){1'b0}}, in_a};
    assign b_ext = {{(P - WIDTH){1'b0}}, in_b};

    // Low limb of each operand plus the running carry; on subtract B is already
    // inverted and the initial carry supplies the +1 of the two's complement.
    assign limb_sum = {1'b0, a_q[LIMB-1:0]} + {1'b0, b_q[LIMB-1:0]}
                    + {{LIMB{1'b0}}, carry_q};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (cnt_q == LAST_LIMB) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath control decoded from the current state
    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        unique case (state_q)
            StIdle:  load   = start;
            StRun:   step   = 1'b1;
            StDone:  finish = 1'b1;
            default: ;
        endcase
    end

    // Operand shifters, carry, limb counter and the accumulating sum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (load) begin
            a_q     <= a_ext;
            b_q     <= subtract ? ~b_ext : b_ext;
            carry_q <= subtract;
            cnt_q   <= '0;
        end else if (step) begin
            a_q     <= {{LIMB{1'b0}}, a_q[P-1:LIMB]};
            b_q     <= {{LIMB{1'b0}}, b_q[P-1:LIMB]};
            // New limb enters at the top; after NLIMB steps limb 0 sits at the bottom
            sum_q   <= {limb_sum[LIMB-1:0], sum_q[P-1:LIMB]};
            // The final carry out of bit P-1 is simply left here and never used
            carry_q <= limb_sum[LIMB];
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    // Registered result and one-cycle done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= finish;
            if (finish) begin
                result_q <= sum_q[WIDTH:0];
            end
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule
